// File: rtl/mips_bus_lsu.sv
// Load/store unit between the multicycle core and an Avalon-style memory bus.
// Core requests are queued in order; one bus access is issued at a time.
// The unit builds byte enables and lane-aligned store data, and it extracts
// and extends load data. It flags misaligned accesses and bus timeouts.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   req_valid/req_ready            core request handshake
//   req_write/size/signed/addr/wdata  request payload
//   rsp_valid/rsp_rdata/rsp_err    registered one-cycle response
//   idle                           queue empty and FSM idle
//   address/read/write/writedata/byteenable/waitrequest/readdata  bus side
module mips_bus_lsu #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                idle,
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int unsigned BYTES    = DATA_W / 8;
  localparam int unsigned OFS_W    = $clog2(BYTES);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TO_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          NO_DWORD = (DATA_W == 32);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              sgn;
    logic              mis;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t            mem [FIFO_DEPTH];
  entry_t            req_entry;
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  count, count_after;
  logic              full, push, pop, req_mis, next_mis;

  logic [1:0]        state, state_d;
  logic [TO_W-1:0]   wait_cnt, wait_d;
  logic              rsp_valid_d, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_d;

  logic [OFS_W-1:0]  ofs;
  logic [BYTES-1:0]  be_base;
  logic [7:0]        wbits;
  logic [6:0]        sh;
  logic [DATA_W-1:0] shifted, left, ext_u, ext_s, ext;
  logic signed [DATA_W-1:0] left_s;
  logic              issue;

  // Misalignment is decided once, when the request enters the queue.
  always_comb begin
    req_mis = 1'b0;
    case (req_size)
      2'd0:    req_mis = 1'b0;
      2'd1:    req_mis = req_addr[0];
      2'd2:    req_mis = |req_addr[1:0];
      default: req_mis = (|req_addr[2:0]) || NO_DWORD;
    endcase
  end

  always_comb begin
    req_entry.write = req_write;
    req_entry.size  = req_size;
    req_entry.sgn   = req_signed;
    req_entry.mis   = req_mis;
    req_entry.addr  = req_addr;
    req_entry.wdata = req_wdata;
  end

  // Queue bookkeeping; a full queue refuses even while popping.
  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign req_ready   = !full;
  assign push        = req_valid && !full;
  assign pop         = (state == S_RESP);
  assign head        = mem[rd_ptr];
  assign rd_ptr_nxt  = rd_ptr + PTR_W'(1);
  assign count_after = count + CNT_W'(push) - CNT_W'(1);
  // Head after the pop: the next stored entry, or the one arriving right now.
  assign next_mis    = (count > CNT_W'(1)) ? mem[rd_ptr_nxt].mis : req_mis;
  assign idle        = (count == '0) && (state == S_IDLE);

  // Queue storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_entry;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Lane arithmetic and load extraction for the head entry.
  always_comb begin
    ofs     = head.addr[OFS_W-1:0];
    be_base = BYTES'((16'd1 << (5'd1 << head.size)) - 16'd1);
    wbits   = 8'd8 << head.size;
    // Left-then-right shift by (DATA_W - access width) keeps the low bits and extends.
    if (32'(wbits) >= DATA_W) sh = 7'd0;
    else                      sh = 7'(DATA_W - 32'(wbits));
    shifted = readdata >> {ofs, 3'b000};
    left    = shifted << sh;
    left_s  = left;
    ext_s   = left_s >>> sh;
    ext_u   = left >> sh;
    ext     = head.sgn ? ext_s : ext_u;
  end

  // Bus outputs are live only in ISSUE.
  always_comb begin
    issue      = (state == S_ISSUE);
    read       = issue && !head.write;
    write      = issue && head.write;
    address    = issue ? {head.addr[ADDR_W-1:OFS_W], OFS_W'(0)} : '0;
    writedata  = issue ? (head.wdata << {ofs, 3'b000}) : '0;
    byteenable = issue ? (be_base << ofs) : '0;
  end

  // Next-state and response logic.
  always_comb begin
    state_d     = state;
    wait_d      = wait_cnt;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          if (head.mis) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            wait_d  = '0;
          end
        end
      end
      S_ISSUE: begin
        if (!waitrequest) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = head.write ? '0 : ext;
        end else if ((TIMEOUT != 0) && (wait_cnt == TO_W'(TIMEOUT))) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_cnt + TO_W'(1);
        end
      end
      S_RESP: begin
        if (count_after != '0) begin
          if (next_mis) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            wait_d  = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      wait_cnt  <= wait_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_lsu.sv
// Self-checking bench for mips_bus_lsu (DATA_W=32, FIFO_DEPTH=4, TIMEOUT=8).
module tb_mips_bus_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, idle;
  logic [31:0] rsp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  logic        use_fn;
  logic [31:0] rd_reg;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  rsp_t sb[$];
  vec_t vt[13];
  vec_t vx;
  int   checks = 0;
  int   errors = 0;
  bit   ok, drained;
  int   acc, cnt;
  rsp_t e;

  mips_bus_lsu #(
    .DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .idle(idle),
    .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  // Memory model: data is a fixed function of the word address.
  function automatic logic [31:0] fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign readdata = use_fn ? fn(address) : rd_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every response is compared with the oldest expectation.
  always @(negedge clk) begin : mon
    rsp_t m;
    if (reset) begin
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected actual=1 required=0");
        end else begin
          m = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, m.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(m.err));
        end
      end
      if (read || write) begin
        chk("rd_wr_exclusive", 32'(read && write), 32'd0);
        chk("addr_low_bits", 32'(address[1:0]), 32'd0);
      end
    end
  end

  task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input rsp_t ex, input int bound, output bit acc_ok);
    acc_ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      if (req_ready) begin
        sb.push_back(ex);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc_ok = 1'b1;
        break;
      end
    end
    if (!acc_ok) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  // One isolated access with zero wait; checks bus fields and latency.
  task automatic run_vec(input vec_t v, input int idx);
    rsp_t ex;
    bit   a_ok;
    int   bus, lat;
    use_fn      = 1'b0;
    rd_reg      = v.rdata;
    waitrequest = 1'b0;
    ex.rdata    = v.e_rdata;
    ex.err      = v.e_err;
    send(v.wr, v.size, v.sgn, v.addr, v.wdata, ex, 6, a_ok);
    chk($sformatf("v%0d_accept", idx), 32'(a_ok), 32'd1);
    bus = 0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (read || write) begin
        bus++;
        if (bus == 1) begin
          chk($sformatf("v%0d_address", idx), address, v.e_addr);
          chk($sformatf("v%0d_byteenable", idx), 32'(byteenable), 32'(v.e_be));
          chk($sformatf("v%0d_writedata", idx), writedata, v.e_wdata);
          chk($sformatf("v%0d_write", idx), 32'(write), 32'(v.wr));
        end
      end
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), v.e_err ? 32'd2 : 32'd3);
    chk($sformatf("v%0d_bus_cycles", idx), 32'(bus), v.e_err ? 32'd0 : 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0};
    vt[1]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80, 1'b0};
    vt[2]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 32'h100, 4'h8, 32'h0, 32'h00000080, 1'b0};
    vt[3]  = '{1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80112233, 32'h100, 4'hC, 32'h0, 32'hFFFF8011, 1'b0};
    vt[4]  = '{1'b0, 2'd1, 1'b0, 32'h000, 32'h0, 32'h1234F00D, 32'h000, 4'h3, 32'h0, 32'h0000F00D, 1'b0};
    vt[5]  = '{1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'h00007F00, 32'h100, 4'h2, 32'h0, 32'h0000007F, 1'b0};
    vt[6]  = '{1'b1, 2'd0, 1'b0, 32'h105, 32'hAA, 32'hFFFFFFFF, 32'h104, 4'h2, 32'h0000AA00, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 2'd2, 1'b0, 32'h300, 32'h12345678, 32'hFFFFFFFF, 32'h300, 4'hF, 32'h12345678, 32'h0, 1'b0};
    vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hFFFFFFFF, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
    vt[9]  = '{1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 32'hFFFFFFFF, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
    vt[10] = '{1'b0, 2'd1, 1'b1, 32'h101, 32'h0, 32'hFFFFFFFF, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
    vt[11] = '{1'b0, 2'd2, 1'b1, 32'h10C, 32'h0, 32'h80000001, 32'h10C, 4'hF, 32'h0, 32'h80000001, 1'b0};
    vt[12] = '{1'b1, 2'd1, 1'b0, 32'h206, 32'h1234, 32'h0, 32'h204, 4'hC, 32'h12340000, 32'h0, 1'b0};

    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    waitrequest = 1'b0; use_fn = 1'b0; rd_reg = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_address", address, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_byteenable", 32'(byteenable), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    reset = 1'b1;

    // Table of isolated accesses.
    for (int i = 0; i < 13; i++) run_vec(vt[i], i);

    // Half store held off by waitrequest for three edges.
    waitrequest = 1'b1;
    e.rdata = 32'h0; e.err = 1'b0;
    send(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000ABCD, e, 6, ok);
    chk("st_accept", 32'(ok), 32'd1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (write) begin
        cnt++;
        chk("st_address", address, 32'h200);
        chk("st_byteenable", 32'(byteenable), 32'hC);
        chk("st_writedata", writedata, 32'hABCD0000);
        if (cnt == 4) waitrequest = 1'b0;
      end
      if (rsp_valid) break;
    end
    chk("st_write_cycles", 32'(cnt), 32'd4);
    @(negedge clk);
    chk("st_single_rsp", 32'(rsp_valid), 32'd0);

    // Queue fill with a stalled bus, then in-order drain.
    waitrequest = 1'b1;
    use_fn = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      e.rdata = fn(32'h400 + 32'(4 * acc)); e.err = 1'b0;
      send(1'b0, 2'd2, 1'b0, 32'h400 + 32'(4 * acc), 32'h0, e, 1, ok);
      if (ok) acc++;
    end
    chk("fifo_accepted", 32'(acc), 32'd4);
    chk("fifo_ready_low", 32'(req_ready), 32'd0);
    chk("fifo_idle_low", 32'(idle), 32'd0);
    waitrequest = 1'b0;
    while (acc < 6) begin
      e.rdata = fn(32'h400 + 32'(4 * acc)); e.err = 1'b0;
      send(1'b0, 2'd2, 1'b0, 32'h400 + 32'(4 * acc), 32'h0, e, 10, ok);
      chk("fifo_late_accept", 32'(ok), 32'd1);
      acc++;
    end
    drained = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) begin
        drained = 1'b1;
        break;
      end
      chk("fifo_idle_busy", 32'(idle), 32'd0);
    end
    chk("fifo_drained", 32'(drained), 32'd1);
    chk("fifo_idle_last_rsp", 32'(idle), 32'd0);
    @(negedge clk);
    chk("fifo_idle_after", 32'(idle), 32'd1);

    // Bus timeout after TIMEOUT wait cycles, then normal service resumes.
    waitrequest = 1'b1;
    e.rdata = 32'h0; e.err = 1'b1;
    send(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, e, 6, ok);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read) cnt++;
      if (rsp_valid) break;
    end
    chk("to_read_cycles", 32'(cnt), 32'd9);
    vx = '{1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 32'h0BADF00D, 32'h504, 4'hF, 32'h0, 32'h0BADF00D, 1'b0};
    run_vec(vx, 90);

    // Reset while an access is stalled on the bus.
    waitrequest = 1'b1;
    e.rdata = 32'h0; e.err = 1'b0;
    send(1'b0, 2'd2, 1'b0, 32'h600, 32'h0, e, 6, ok);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (read) begin
        cnt = 1;
        break;
      end
    end
    chk("rst_mid_issue_seen", 32'(cnt), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    chk("rst_mid_read", 32'(read), 32'd0);
    chk("rst_mid_address", address, 32'd0);
    chk("rst_mid_idle", 32'(idle), 32'd1);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_vec(vt[0], 91);

    repeat (3) @(negedge clk);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_lsu.md
Name: mips_bus_lsu

Overview:
Parametrised load/store unit that sits between the multicycle core datapath and the Avalon-style memory bus (address/read/write/waitrequest/byteenable). It buffers core memory requests in an in-order FIFO and issues one bus transaction at a time, stalling while waitrequest is high. It generates byte enables and lane-aligned write data, then extracts and sign/zero-extends read data. Unlike the current fixed 32-bit bus path, it adds configurable data width and queue depth, misalignment detection and a bus timeout.

Parameters:
DATA_W, 32, bus/data width in bits; 32 or 64 only. BYTES = DATA_W/8, OFS_W = log2(BYTES).
ADDR_W, 32, byte address width.
FIFO_DEPTH, 4, request queue entries; power of two, at least 2.
TIMEOUT, 255, maximum wait cycles per bus access; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  queue can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_W = 64)
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-justified
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or timed-out access
idle  out  1  FIFO empty and FSM in IDLE
address  out  ADDR_W  bus address, low OFS_W bits always 0
read  out  1  bus read strobe
write  out  1  bus write strobe
waitrequest  in  1  slave stall
writedata  out  DATA_W  lane-aligned store data
byteenable  out  BYTES  active lanes
readdata  in  DATA_W  valid in the cycle waitrequest is low

Behaviour:
- Reset (reset = 0) acts immediately and asynchronously. It clears the FIFO, sets the FSM to IDLE, clears the timeout counter and forces these values: read=0, write=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, address=0, writedata=0, byteenable=0, req_ready=1, idle=1. An in-flight access is dropped with no response.
- Accept rule: a request is accepted when req_valid && req_ready. req_ready = !full. There is no bypass: a full queue refuses requests even in a pop cycle.
- Misalignment is evaluated at accept time and stored with the entry. An entry is misaligned when (addr mod 2^size) != 0, or when size = 3 and DATA_W = 32.
- Lane arithmetic: ofs = addr[OFS_W-1:0].
  - byteenable = ((1 << 2^size) - 1) << ofs.
  - writedata = req_wdata << (8*ofs).
  - address = {addr[ADDR_W-1:OFS_W], 0}.
  - Byte lane k = data bits [8k+7:8k] (little-endian).
- Load extraction: shift readdata right by 8*ofs, keep 8*2^size bits, then extend to DATA_W. Sign-extend if req_signed, otherwise zero-extend. A full-width size is passed unchanged.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if the FIFO is not empty, go to ISSUE when the head entry is aligned, or to RESP with err=1 when it is misaligned.
  - ISSUE: drive read or write, address, byteenable and writedata combinationally from the head entry. Hold them stable while waitrequest=1.
    - If waitrequest=0, capture the extracted data (loads) and go to RESP.
    - If TIMEOUT != 0 and the wait counter reaches TIMEOUT, go to RESP with err=1 and rdata=0. read/write then deassert in the next cycle.
    - The wait counter increments each ISSUE cycle in which waitrequest=1 and clears on entering ISSUE.
  - RESP: rsp_valid=1 for exactly one cycle and the head entry is popped. Next state is ISSUE (or RESP for a misaligned entry) if entries remain after the pop, otherwise IDLE.
- Outside ISSUE, read, write, address, writedata and byteenable are all 0.
- Responses are strictly in request order, one per accepted request.
- Minimum latency: accept at edge N. read/write is high during cycle N+1→N+2 (ISSUE entered at edge N+1). With zero wait, rsp_valid is high in the following cycle, i.e. 2 cycles after accept. Back-to-back throughput is one access per 2 cycles.
- read and write are never high together.
- idle = FIFO empty && state == IDLE.

Test Plan:
- Word load from 0x100 (DATA_W=32), waitrequest=0, readdata=0xDEADBEEF → read=1 for one cycle, address=0x100, byteenable=4'b1111; then rsp_valid=1 with rsp_rdata=0xDEADBEEF and rsp_err=0.
- Signed byte load from 0x103, readdata=0x80112233 → byteenable=4'b1000, rsp_rdata=0xFFFFFF80. The same access unsigned → 0x00000080.
- Half store to 0x202 with wdata=0x0000ABCD and waitrequest held high 3 cycles → write high for 4 cycles with address=0x200, byteenable=4'b1100, writedata=0xABCD0000 held stable; exactly one rsp_valid with rdata=0.
- FIFO_DEPTH=4, waitrequest stuck high, 6 back-to-back requests → req_ready drops once 4 entries are queued. Releasing waitrequest returns responses in issue order; idle=1 only after the last response.
- Misaligned word load at 0x102, and dword with DATA_W=32 → no read/write activity, rsp_err=1, rsp_rdata=0. The following aligned request completes normally.
- TIMEOUT=8, waitrequest stuck high → read high for 9 cycles, then rsp_err=1 and the next request issues. Separately, assert reset mid-ISSUE → read drops in the same cycle, no rsp_valid, idle=1.
